serial_operand_loader: RTL
==========================

// Module: serial_operand_loader
// PURPOSE
//  Upstream stage of the serial adder FSM. Accepts two WIDTH-bit operands through a valid/ready
//  handshake and presents them LSB-first, one bit pair per transfer, to the FSM.
//  Marks the first and last bit so the FSM can clear and finish its carry.
//  Pulses done once the final bit pair has been consumed.
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range 1..32
//  CNT_W  derived localparam = $clog2(WIDTH+1); not overridable
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair on op_a/op_b is valid
//  in_ready   out  1      loader can accept an operand pair
//  op_a       in   WIDTH  operand A; sampled on accept
//  op_b       in   WIDTH  operand B; sampled on accept
//  bit_a      out  1      current bit of A; 0 when bit_valid=0
//  bit_b      out  1      current bit of B; 0 when bit_valid=0
//  bit_valid  out  1      bit_a/bit_b/bit_first/bit_last are valid
//  bit_ready  in   1      FSM consumes the current bit pair this cycle
//  bit_first  out  1      current pair is bit 0; FSM clears carry
//  bit_last   out  1      current pair is bit WIDTH-1
//  done       out  1      one-cycle pulse after the last pair is consumed
// BEHAVIOUR
//  - Reset: state=IDLE, shift regs=0, count=0, bit_valid=0, done=0.
//    Outputs after reset: in_ready=1; bit_first=bit_last=0.
//  - States: IDLE, SHIFT, DONE.
//    - IDLE: in_ready=1. Accept = in_valid & in_ready. On accept, latch op_a/op_b into sh_a/sh_b,
//      set count=0 and go to SHIFT.
//    - SHIFT: bit_valid=1, in_ready=0, bit_a=sh_a[0], bit_b=sh_b[0].
//      Transfer = bit_valid & bit_ready. On transfer, shift sh_a/sh_b right by 1 and increment count.
//      On the transfer with count==WIDTH-1, go to DONE.
//    - DONE: done=1 for exactly one cycle, in_ready=0, bit_valid=0; then go to IDLE.
//  - Flags: bit_first = bit_valid & (count==0); bit_last = bit_valid & (count==WIDTH-1).
//  - Stall: bit_ready=0 holds every bit_* output and count stable, for any number of cycles.
//  - Latency with bit_ready tied high, accept on cycle 0:
//    first pair valid on cycle 1, last pair on cycle WIDTH, done on cycle WIDTH+1,
//    in_ready=1 again on cycle WIDTH+2.
//  - in_valid is ignored outside IDLE; op_a/op_b are never resampled mid-operation.
//  - WIDTH=1: the single pair has bit_first=bit_last=1; DONE follows its transfer.
//  - rst mid-operation: the next edge returns to the reset values; the partial operand is discarded
//    and done is not pulsed.
//  - rst has priority over accept and over transfer in the same cycle.
//  - Counter never exceeds WIDTH-1 while in SHIFT; no wrap-around.
// STRUCTURE
//  - Shared header serial_adder_defs.vh holds the state encodings (IDLE=2'd0, SHIFT=2'd1,
//    DONE=2'd2) and the default WIDTH. The FSM and its bench include the same header.
//  - One sub-module: piso_shift_reg #(WIDTH), a parallel-load, right-shift register with
//    load/shift enables. Two instances, for A and B.
//  - Control FSM and counter stay in this module; all outputs are decoded from state/count/shift regs.
// TESTING
//  1. Reset, then idle: in_ready=1, bit_valid=0, done=0 for all cycles until in_valid is asserted.
//  2. WIDTH=8, op_a=8'hA5, op_b=8'h3C, bit_ready=1:
//     bit_a sequence 1,0,1,0,0,1,0,1; bit_b sequence 0,0,1,1,1,1,0,0.
//     bit_first on cycle 1, bit_last on cycle 8, done on cycle 9.
//  3. Same operands, bit_ready low for 3 cycles at bit 4: outputs frozen at bit 4 while stalled;
//     sequence resumes intact; done is delayed by 3 cycles.
//  4. in_valid held high with new operands 8'hFF during SHIFT: ignored.
//     Second accept occurs only on cycle WIDTH+2; the first result stream is unchanged.
//  5. rst asserted at bit 3: next cycle bit_valid=0, in_ready=1, no done pulse.
//     A fresh load then restarts at bit_first.
//  6. WIDTH=1, op_a=1, op_b=1: one pair (1,1) with bit_first=bit_last=1; done on the following cycle.

Source files
------------

// File: rtl/serial_operand_loader_pkg.sv
// Shared definitions for the serial operand loader: FSM state encodings and default width.
package serial_operand_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } loader_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_operand_loader_piso.sv
// Parallel-load, right-shift register; bit 0 is the serial output.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= r_data >> 1;
        end
    end

    assign o_lsb = r_data[0];

endmodule

// File: rtl/serial_operand_loader.sv
// Accepts an operand pair and streams it LSB-first as bit pairs, flagging first/last bit
// and pulsing done once the final pair has been consumed.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  ST_IDLE  | waiting for an operand pair (in_ready=1)
//  ST_SHIFT | presenting bit pair r_count, advancing on bit_ready
//  ST_DONE  | one-cycle done pulse, then back to idle
module serial_operand_loader
    import serial_operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             bit_a,
    output logic             bit_b,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_first,
    output logic             bit_last,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    loader_state_t    r_state;
    loader_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_transfer;
    logic             w_last;
    logic             w_lsb_a;
    logic             w_lsb_b;

    assign w_accept   = in_valid & (r_state == ST_IDLE);
    assign w_transfer = bit_ready & (r_state == ST_SHIFT);
    assign w_last     = (r_count == LAST_CNT);

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_transfer),
        .i_data  (op_a),
        .o_lsb   (w_lsb_a)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_transfer),
        .i_data  (op_b),
        .o_lsb   (w_lsb_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Count saturates at the last bit so it never wraps.
            if (w_accept) begin
                r_count <= '0;
            end else if (w_transfer && !w_last) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        bit_valid   = 1'b0;
        bit_a       = 1'b0;
        bit_b       = 1'b0;
        bit_first   = 1'b0;
        bit_last    = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_valid = 1'b1;
                bit_a     = w_lsb_a;
                bit_b     = w_lsb_b;
                bit_first = (r_count == '0);
                bit_last  = w_last;
                if (bit_ready && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
